// File: rtl/ex_result_stage.sv
// Execute-stage result buffer: selects word/full ALU result, tags it with rd/write-enable,
// and holds it in a 2-entry skid buffer whose head doubles as a bypass source.
module ex_result_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_word,
    input  logic [XLEN-1:0]       in_result64,
    input  logic [XLEN-1:0]       in_result32,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic [XLEN-1:0]       out_pc,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]       head_result_q, head_result_d;
    logic [REG_ADDR_W-1:0] head_rd_q, head_rd_d;
    logic                  head_we_q, head_we_d;
    logic [XLEN-1:0]       head_pc_q, head_pc_d;
    logic [XLEN-1:0]       skid_result_q, skid_result_d;
    logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
    logic                  skid_we_q, skid_we_d;
    logic [XLEN-1:0]       skid_pc_q, skid_pc_d;

    logic                  accept;
    logic                  pop;
    logic [XLEN-1:0]       in_data;
    logic                  in_we;
    logic                  load_head_in;
    logic                  load_skid;
    logic                  move_skid;

    // Valid/ready: a transfer happens on a rising edge where valid & ready are both high;
    // in_ready and out_valid are pure decodes of the registered state.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign in_data = in_is_word ? in_result32 : in_result64;
    assign in_we   = in_reg_write & (in_rd != '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !pop) begin
                    state_d = ST_FULL;
                end else if (!accept && pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Payload steering: new data lands in head when head is free or leaving, else in skid.
    always_comb begin
        load_head_in  = !flush && accept && ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && pop));
        load_skid     = !flush && accept && (state_q == ST_ONE) && !pop;
        move_skid     = !flush && pop && (state_q == ST_FULL);
        head_result_d = head_result_q;
        head_rd_d     = head_rd_q;
        head_we_d     = head_we_q;
        head_pc_d     = head_pc_q;
        skid_result_d = skid_result_q;
        skid_rd_d     = skid_rd_q;
        skid_we_d     = skid_we_q;
        skid_pc_d     = skid_pc_q;
        if (load_head_in) begin
            head_result_d = in_data;
            head_rd_d     = in_rd;
            head_we_d     = in_we;
            head_pc_d     = in_pc;
        end else if (move_skid) begin
            head_result_d = skid_result_q;
            head_rd_d     = skid_rd_q;
            head_we_d     = skid_we_q;
            head_pc_d     = skid_pc_q;
        end
        if (load_skid) begin
            skid_result_d = in_data;
            skid_rd_d     = in_rd;
            skid_we_d     = in_we;
            skid_pc_d     = in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_result_q <= '0;
            head_rd_q     <= '0;
            head_we_q     <= 1'b0;
            head_pc_q     <= '0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_we_q     <= 1'b0;
            skid_pc_q     <= '0;
        end else begin
            head_result_q <= head_result_d;
            head_rd_q     <= head_rd_d;
            head_we_q     <= head_we_d;
            head_pc_q     <= head_pc_d;
            skid_result_q <= skid_result_d;
            skid_rd_q     <= skid_rd_d;
            skid_we_q     <= skid_we_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

    // Output decode; only the head is ever offered to the bypass network.
    always_comb begin
        out_result    = head_result_q;
        out_rd        = head_rd_q;
        out_reg_write = head_we_q;
        out_pc        = head_pc_q;
        fwd_valid     = out_valid & head_we_q;
        fwd_rd        = head_rd_q;
        fwd_data      = head_result_q;
    end

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: directed scenarios plus a randomized
// phase checked against an in-order reference queue.
module tb_ex_result_stage;

    localparam int XLEN  = 64;
    localparam int RW    = 5;
    localparam int ENT_W = XLEN + RW + 1 + XLEN;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            in_is_word;
    logic [XLEN-1:0] in_result64;
    logic [XLEN-1:0] in_result32;
    logic [RW-1:0]   in_rd;
    logic            in_reg_write;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RW-1:0]   out_rd;
    logic            out_reg_write;
    logic [XLEN-1:0] out_pc;
    logic            fwd_valid;
    logic [RW-1:0]   fwd_rd;
    logic [XLEN-1:0] fwd_data;

    logic [ENT_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    logic             held_v = 1'b0;
    logic [ENT_W-1:0] held_p = '0;

    ex_result_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_word(in_is_word),
        .in_result64(in_result64), .in_result32(in_result32), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_pc(out_pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference: what the memory stage should see for a given execute-stage result.
    function automatic logic [ENT_W-1:0] model(input logic w, input logic [XLEN-1:0] r64,
                                               input logic [XLEN-1:0] r32, input logic [RW-1:0] rd,
                                               input logic rw, input logic [XLEN-1:0] pc);
        logic [XLEN-1:0] res;
        logic            we;
        res = w ? r32 : r64;
        we  = rw && (rd != 0);
        return {res, rd, we, pc};
    endfunction

    // Driver tasks
    task automatic set_in(input logic v, input logic w, input logic [XLEN-1:0] r64,
                          input logic [XLEN-1:0] r32, input logic [RW-1:0] rd,
                          input logic rw, input logic [XLEN-1:0] pc);
        in_valid     = v;
        in_is_word   = w;
        in_result64  = r64;
        in_result32  = r32;
        in_rd        = rd;
        in_reg_write = rw;
        in_pc        = pc;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst && !flush && in_valid && in_ready)
            exp_q.push_back(model(in_is_word, in_result64, in_result32, in_rd, in_reg_write, in_pc));
        #1;
    endtask

    task automatic push(input logic w, input logic [XLEN-1:0] r64, input logic [XLEN-1:0] r32,
                        input logic [RW-1:0] rd, input logic rw, input logic [XLEN-1:0] pc);
        set_in(1'b1, w, r64, r32, rd, rw, pc);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cycle();
    endtask

    // Monitor: compares every handed-off head against the reference queue.
    always @(posedge clk) begin
        logic [ENT_W-1:0] e;
        logic [ENT_W-1:0] p;
        p = {out_result, out_rd, out_reg_write, out_pc};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", {{(ENT_W-1){1'b0}}, out_valid}, {{(ENT_W-1){1'b0}}, 1'b1});
                check("stall_payload", p, held_p);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", p, '0);
                    if (p == '0) begin
                        bad++;
                        $display("FAIL unexpected_out act=valid exp=empty");
                    end
                end else begin
                    e = exp_q.pop_front();
                    check("out_entry", p, e);
                    check("fwd_entry", {fwd_data, fwd_rd, fwd_valid, {XLEN{1'b0}}},
                          {e[ENT_W-1 -: XLEN], e[XLEN+RW : XLEN+1], e[XLEN], {XLEN{1'b0}}});
                end
            end
            held_v = out_valid && !out_ready && !flush;
            held_p = p;
            if (flush) exp_q.delete();
        end
    end

    initial begin
        logic [XLEN-1:0] a64;
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        #2;
        check("rst_out_valid", ENT_W'(out_valid), ENT_W'(0));
        check("rst_payload", {out_result, out_rd, out_reg_write, out_pc}, '0);
        check("rst_fwd", {fwd_data, fwd_rd, fwd_valid}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", ENT_W'(in_ready), ENT_W'(1));

        // Word vs full select
        out_ready = 1'b1;
        push(1'b1, 64'h1, 64'hFFFFFFFF_80000000, 5'd5, 1'b1, 64'h1000);
        check("word_sel", {out_valid, out_result, out_rd, fwd_valid},
              {1'b1, 64'hFFFFFFFF_80000000, 5'd5, 1'b1});
        push(1'b0, 64'h1, 64'hFFFFFFFF_80000000, 5'd5, 1'b1, 64'h1004);
        check("full_sel", {out_valid, out_result, fwd_data}, {1'b1, 64'h1, 64'h1});

        // x0 suppression
        push(1'b0, 64'hABCD, 64'h0, 5'd0, 1'b1, 64'h1008);
        check("x0_sup", {out_valid, out_reg_write, fwd_valid}, {1'b1, 1'b0, 1'b0});
        idle();
        check("empty_after", ENT_W'(out_valid), ENT_W'(0));

        // Backpressure / skid
        out_ready = 1'b0;
        push(1'b0, 64'hA, 64'h0, 5'd1, 1'b1, 64'h2000);
        push(1'b0, 64'hB, 64'h0, 5'd2, 1'b1, 64'h2004);
        check("full_in_ready", ENT_W'(in_ready), ENT_W'(0));
        check("full_head", out_result, 64'hA);
        push(1'b0, 64'hC, 64'h0, 5'd3, 1'b1, 64'h2008);
        check("full_hold", {out_valid, out_result}, {1'b1, 64'hA});
        out_ready = 1'b1;
        idle();
        check("skid_move", {out_result, in_ready}, {64'hB, 1'b1});
        idle();
        check("skid_drain", ENT_W'(out_valid), ENT_W'(0));

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            push(1'b0, 64'(i), 64'h0, 5'(i), 1'b1, 64'(32'h3000 + 4 * i));
            check("stream", {in_ready, out_valid, out_result}, {1'b1, 1'b1, 64'(i)});
        end
        idle();

        // Flush while full with a same-cycle push
        out_ready = 1'b0;
        push(1'b0, 64'h11, 64'h0, 5'd7, 1'b1, 64'h4000);
        push(1'b0, 64'h22, 64'h0, 5'd8, 1'b1, 64'h4004);
        flush = 1'b1;
        push(1'b0, 64'h33, 64'h0, 5'd9, 1'b1, 64'h4008);
        flush = 1'b0;
        check("flush_state", {out_valid, in_ready}, {1'b0, 1'b1});
        out_ready = 1'b1;
        repeat (3) idle();
        check("flush_no_c", ENT_W'(out_valid), ENT_W'(0));

        // Async reset mid-stream
        out_ready = 1'b0;
        push(1'b0, 64'h55, 64'h0, 5'd4, 1'b1, 64'h5000);
        push(1'b0, 64'h66, 64'h0, 5'd6, 1'b1, 64'h5004);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {out_valid, fwd_valid}, '0);
        check("arst_payload", {out_result, out_rd, out_reg_write, out_pc}, '0);
        exp_q.delete();
        cycle();
        rst = 1'b0;
        check("arst_in_ready", ENT_W'(in_ready), ENT_W'(1));
        out_ready = 1'b1;
        push(1'b0, 64'h77, 64'h0, 5'd10, 1'b1, 64'h6000);
        check("arst_first", {out_valid, out_result}, {1'b1, 64'h77});
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            a64 = {$urandom, $urandom};
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a64,
                   {{32{a64[31]}}, a64[31:0]} ^ 64'h5A5A, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   1'($urandom_range(0, 1)), {$urandom, $urandom});
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            cycle();
            flush = 1'b0;
        end

        // Drain with bounded wait
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
        check("drain_queue", ENT_W'(exp_q.size()), ENT_W'(0));
        idle();
        check("drain_valid", ENT_W'(out_valid), ENT_W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Execute-stage output buffer that sits directly downstream of the 64-bit ALU and the 32-bit word ALU (OP_32 / OP_32_IMM path).
- Each cycle it selects the word-op result or the full 64-bit result, then tags it with destination register and write-enable.
- It holds the tagged result in a 2-entry skid buffer with a valid/ready handshake toward the memory stage.
- It exposes its head entry as a forwarding source for the operand bypass network.

Parameters:
- XLEN, 64, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous pipeline flush (branch mispredict/trap).
- in_valid  input  1  execute stage presents a result.
- in_ready  output  1  buffer can accept this cycle.
- in_is_word  input  1  1 = select in_result32 (W-type op).
- in_result64  input  XLEN  64-bit ALU result.
- in_result32  input  XLEN  word ALU result, already sign-extended to 64 bits.
- in_rd  input  REG_ADDR_W  destination register.
- in_reg_write  input  1  instruction writes rd.
- in_pc  input  XLEN  instruction PC, carried for trap reporting.
- out_valid  output  1  head entry valid.
- out_ready  input  1  memory stage accepts head.
- out_result  output  XLEN  head result.
- out_rd  output  REG_ADDR_W  head rd.
- out_reg_write  output  1  head write-enable.
- out_pc  output  XLEN  head PC.
- fwd_valid  output  1  head is a legal bypass source.
- fwd_rd  output  REG_ADDR_W  bypass register index.
- fwd_data  output  XLEN  bypass value.

Behaviour:
- Selection at capture: data = in_is_word ? in_result32 : in_result64. No further extension; in_result32 is used verbatim.
- Effective write-enable = in_reg_write & (in_rd != 0). x0 writes are never emitted.
- Storage: head register (drives out_*) and skid register.
- State machine, registered:
  - EMPTY: no entries.
  - ONE: head valid.
  - FULL: head and skid valid.
- in_ready = (state != FULL). It is a registered decode and does not combinationally depend on out_ready.
- accept = in_valid & in_ready.
- pop = out_valid & out_ready.
- Transitions:
  - EMPTY, accept → ONE; input goes to head.
  - ONE, accept & !pop → FULL; input goes to skid.
  - ONE, accept & pop → ONE; input replaces head.
  - ONE, !accept & pop → EMPTY.
  - FULL, pop → ONE; skid moves to head. No accept is possible in FULL.
  - All other cases hold state.
- Latency: an accepted entry appears on out_* the cycle after acceptance when the buffer is EMPTY, or when it is ONE and the head pops that same cycle.
- Throughput: 1 entry/cycle with out_ready held high.
- Ordering is strict FIFO. No entry is dropped or duplicated except on flush.
- Flush has priority over all events:
  - Next state is EMPTY and both valids clear.
  - A same-cycle accept is discarded.
  - A same-cycle pop still counts as consumed downstream.
  - in_ready = 1 the cycle after.
- Reset (async assert):
  - state = EMPTY, out_valid = 0, in_ready = 1 after release.
  - out_result, out_rd, out_reg_write, out_pc, fwd_* = 0.
  - Reset mid-transfer drops all entries.
- Payload registers update only on capture/move. They hold their value while not valid, but consumers must qualify them with out_valid.
- fwd_valid = out_valid & out_reg_write; fwd_rd = out_rd; fwd_data = out_result. The skid entry is never forwarded; the hazard unit must stall in FULL.
- out_valid and the payload hold stable while out_valid & !out_ready.

Test Plan:
- Word select: in_is_word=1, in_result32=0xFFFFFFFF_80000000, in_result64=0x1, rd=5, reg_write=1, out_ready=1 → next cycle out_result=0xFFFFFFFF_80000000, out_rd=5, fwd_valid=1. Repeat with is_word=0 → out_result=0x1.
- x0 suppression: rd=0, reg_write=1 → out_reg_write=0, fwd_valid=0, out_valid=1.
- Backpressure/skid: out_ready=0, push A then B → state FULL, in_ready=0, out shows A stable. Raise out_ready → A, then B on consecutive cycles; in_ready returns to 1 one cycle after the first pop.
- Streaming: out_ready=1, 8 back-to-back pushes with values 1..8 → outputs 1..8 in order, one per cycle, in_ready constantly 1.
- Flush: FULL with A,B, assert flush together with in_valid C → next cycle out_valid=0, in_ready=1. C never appears.
- Async reset: assert rst mid-stream between clock edges → out_valid and fwd_valid drop immediately, outputs read 0. After release, first push emerges one cycle later.
